// File: rtl/shift_reg_bank.sv
// Bank of DEPTH entries of WIDTH bits. Bytes shift in at entry 0 through a valid/ready
// handshake, and any entry can be parallel-loaded. The bank tracks occupancy and a sticky overflow flag.
module shift_reg_bank #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int CW    = 3,
  parameter int ROLL  = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ready,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic [AW-1:0]          rd_addr,
  output logic [WIDTH-1:0]       rd_data,
  output logic [WIDTH*DEPTH-1:0] q_flat,
  output logic [CW-1:0]          count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    cnt;
  logic             ovf;
  logic             shift;

  assign full     = (cnt == CW'(DEPTH));
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign overflow = ovf;

  // In roll mode a full bank still accepts data by dropping its oldest entry
  assign in_ready = (ROLL != 0) ? (!wr_en && !clr) : (!full && !wr_en && !clr);
  assign shift    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (wr_en) begin
      // Addresses at or above DEPTH match no entry, so the write is dropped
      for (int i = 0; i < DEPTH; i++)
        if (wr_addr == AW'(i)) mem[i] <= wr_data;
    end else if (shift) begin
      for (int i = DEPTH - 1; i > 0; i--) mem[i] <= mem[i-1];
      mem[0] <= in_data;
      if (!full) cnt <= cnt + CW'(1);
      else       ovf <= 1'b1;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++)
      if (rd_addr == AW'(i)) rd_data = mem[i];
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign q_flat[g*WIDTH +: WIDTH] = mem[g];
  end

endmodule

// File: tb/tb_shift_reg_bank.sv
// Drives three bank configurations with shared stimulus (saturating depth 4, rolling depth 4,
// saturating depth 3). Expected results come from a behavioural model and pass through a scoreboard queue.
module tb_shift_reg_bank;

  logic       clk = 1'b0;
  logic       reset, clr, in_valid, wr_en;
  logic [7:0] in_data, wr_data;
  logic [1:0] wr_addr, rd_addr;

  logic        rdy0, rdy1, rdy2;
  logic [7:0]  rd0, rd1, rd2;
  logic [31:0] q0, q1;
  logic [23:0] q2;
  logic [2:0]  c0, c1;
  logic [1:0]  c2;
  logic        f0, f1, f2, e0, e1, e2, o0, o1, o2;

  always #5 clk = ~clk;

  shift_reg_bank #(.WIDTH(8), .DEPTH(4), .AW(2), .CW(3), .ROLL(0)) d0 (
    .clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy0), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd0), .q_flat(q0), .count(c0), .full(f0),
    .empty(e0), .overflow(o0));

  shift_reg_bank #(.WIDTH(8), .DEPTH(4), .AW(2), .CW(3), .ROLL(1)) d1 (
    .clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy1), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd1), .q_flat(q1), .count(c1), .full(f1),
    .empty(e1), .overflow(o1));

  shift_reg_bank #(.WIDTH(8), .DEPTH(3), .AW(2), .CW(2), .ROLL(0)) d2 (
    .clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy2), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd2), .q_flat(q2), .count(c2), .full(f2),
    .empty(e2), .overflow(o2));

  typedef struct {
    int          k;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Behavioural model state for each of the three banks
  logic [7:0] m [3][4];
  int         mcnt [3];
  bit         movf [3];
  int         dep [3] = '{4, 4, 3};
  bit         rl  [3] = '{1'b0, 1'b1, 1'b0};

  function automatic string selName(int sel);
    case (sel)
      0: return "q_flat";
      1: return "count";
      2: return "overflow";
      3: return "full";
      4: return "empty";
      default: return "rd_data";
    endcase
  endfunction

  function automatic logic [31:0] actual(int k, int sel);
    logic [31:0] v;
    v = '0;
    case (k)
      0: case (sel) 0: v = q0; 1: v = 32'(c0); 2: v = 32'(o0); 3: v = 32'(f0); 4: v = 32'(e0); default: v = 32'(rd0); endcase
      1: case (sel) 0: v = q1; 1: v = 32'(c1); 2: v = 32'(o1); 3: v = 32'(f1); 4: v = 32'(e1); default: v = 32'(rd1); endcase
      default: case (sel) 0: v = 32'(q2); 1: v = 32'(c2); 2: v = 32'(o2); 3: v = 32'(f2); 4: v = 32'(e2); default: v = 32'(rd2); endcase
    endcase
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, check the combinational ready, step the model, queue post-edge expectations
  task automatic applyStimulus(input bit rst, input bit c, input bit v, input logic [7:0] d,
                               input bit we, input logic [1:0] wa, input logic [7:0] wd,
                               input logic [1:0] ra);
    bit          rdyExp [3];
    logic [31:0] qe;
    exp_t        e;
    reset = rst; clr = c; in_valid = v; in_data = d;
    wr_en = we; wr_addr = wa; wr_data = wd; rd_addr = ra;
    #1;
    for (int k = 0; k < 3; k++) begin
      rdyExp[k] = !c && !we && (rl[k] || mcnt[k] < dep[k]);
      checkOutput($sformatf("d%0d.in_ready", k),
                  32'(k == 0 ? rdy0 : (k == 1 ? rdy1 : rdy2)), 32'(rdyExp[k]));
    end
    for (int k = 0; k < 3; k++) begin
      if (rst || c) begin
        for (int i = 0; i < 4; i++) m[k][i] = 8'h00;
        mcnt[k] = 0;
        movf[k] = 1'b0;
      end else if (we) begin
        if (int'(wa) < dep[k]) m[k][wa] = wd;
      end else if (v && rdyExp[k]) begin
        if (mcnt[k] == dep[k]) movf[k] = 1'b1;
        else mcnt[k]++;
        for (int i = 3; i > 0; i--) m[k][i] = m[k][i-1];
        m[k][0] = d;
      end
      qe = '0;
      for (int i = 0; i < dep[k]; i++) qe[i*8 +: 8] = m[k][i];
      e.k = k;
      e.sel = 0; e.exp = qe;                                     sb.push_back(e);
      e.sel = 1; e.exp = 32'(mcnt[k]);                           sb.push_back(e);
      e.sel = 2; e.exp = 32'(movf[k]);                           sb.push_back(e);
      e.sel = 3; e.exp = 32'(mcnt[k] == dep[k]);                 sb.push_back(e);
      e.sel = 4; e.exp = 32'(mcnt[k] == 0);                      sb.push_back(e);
      e.sel = 5; e.exp = (int'(ra) < dep[k]) ? 32'(m[k][ra]) : '0; sb.push_back(e);
    end
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput($sformatf("d%0d.%s", e.k, selName(e.sel)), actual(e.k, e.sel), e.exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    applyStimulus(0, 0, 1, d, 0, 2'd0, 8'h00, 2'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      mcnt[k] = 0;
      movf[k] = 1'b0;
      for (int i = 0; i < 4; i++) m[k][i] = 8'h00;
    end
    reset = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    @(posedge clk);
    #1;
    applyStimulus(1, 0, 0, 8'h00, 0, 2'd0, 8'h00, 2'd0);

    // Fill, then hold 0x35 against a full bank
    push(8'h31); push(8'h32); push(8'h33); push(8'h34);
    for (int n = 0; n < 3; n++) push(8'h35);

    // Parallel write wins over a simultaneous push; then an out-of-range write
    applyStimulus(0, 0, 1, 8'h36, 1, 2'd2, 8'hAA, 2'd2);
    applyStimulus(0, 0, 0, 8'h00, 1, 2'd3, 8'h55, 2'd3);
    applyStimulus(0, 0, 0, 8'h77, 0, 2'd0, 8'h00, 2'd1);

    // Clear with a push pending, then refill past capacity
    applyStimulus(0, 1, 1, 8'h30, 0, 2'd0, 8'h00, 2'd0);
    for (int n = 0; n < 5; n++) push(8'(8'h31 + n));

    // Reset beats a valid push; the next byte lands in entry 0
    applyStimulus(1, 0, 1, 8'h39, 0, 2'd0, 8'h00, 2'd0);
    push(8'h36);

    for (int n = 0; n < 40; n++)
      applyStimulus($urandom_range(0, 19) == 0, $urandom_range(0, 14) == 0,
                    1'($urandom_range(0, 1)), 8'($urandom_range(8'h30, 8'h39)),
                    $urandom_range(0, 4) == 0, 2'($urandom_range(0, 3)),
                    8'($urandom), 2'($urandom_range(0, 3)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
